line_sync_ctrl: RTL and testbench

- Schedules reads from the packet-receive FIFO (first-word-fall-through) into the pixel datapath.
- Locks the FIFO word stream to the local video timing generator.
- Discards stale or misaligned words until a word for the correct line is at the head, then pops exactly one word per active pixel.
- Sits between the receive FIFO and the YCbCr-to-RGB pixel stage. Drives the FIFO read strobe and presents aligned 16-bit YC pixel data plus a valid flag.

---
 rtl/line_sync_ctrl.sv | 179 +++++++++++++++++
 tb/tb_line_sync_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_sync_ctrl.sv
// line_sync_ctrl: locks FWFT receive-FIFO words to the local video timing.
// Define STATS_EN to build the per-frame underflow/resync counters.
module line_sync_ctrl #(
    parameter logic [11:0] HSTART   = 12'd1,
    parameter logic [11:0] HACT     = 12'd1280,
    parameter logic [11:0] VSTART   = 12'd24,
    parameter logic [11:0] VACT     = 12'd720,
    parameter logic [15:0] BLANK_YC = 16'h1080
) (
    input  logic        i_clk_74M,
    input  logic        i_rst_n,
    input  logic [11:0] i_vcnt,
    input  logic [11:0] i_hcnt,
    input  logic [28:0] i_fifo_dout,
    input  logic        i_fifo_empty,
    output logic        o_fifo_rd,
    output logic [15:0] o_pix_data,
    output logic        o_pix_valid,
    output logic        o_locked,
    output logic        o_resync,
    output logic [15:0] o_underflow_cnt,
    output logic [15:0] o_resync_cnt
);

    localparam logic [11:0] HEND  = HSTART + HACT;
    localparam logic [11:0] VEND  = VSTART + VACT;
    localparam logic [11:0] HHALF = HACT >> 1;
    localparam logic [11:0] HPRE  = HSTART - 12'd1;
    localparam logic [11:0] HLAST = HACT - 12'd1;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic        resync_q, resync_d;

    logic        act_h, act_v, act;
    logic [11:0] hoff;
    logic [10:0] cur_line, next_line, y_cnt;
    logic [1:0]  x_cnt;
    logic        half, chk_pt, mismatch;
    logic        lock_hit, hold_hit, rd;

    assign x_cnt     = i_fifo_dout[28:27];
    assign y_cnt     = i_fifo_dout[26:16];
    assign act_h     = (i_hcnt >= HSTART) && (i_hcnt < HEND);
    assign act_v     = (i_vcnt >= VSTART) && (i_vcnt < VEND);
    assign act       = act_h && act_v;
    assign hoff      = i_hcnt - HSTART;
    assign cur_line  = 11'(i_vcnt - VSTART);
    assign next_line = act_v ? cur_line + 11'd1 : 11'd0;
    assign half      = hoff >= HHALF;
    assign chk_pt    = act && ((hoff == 12'd0) || (hoff == HHALF));

    assign mismatch = (state_q == LOCK) && chk_pt
                    && !i_fifo_empty
                    && ((y_cnt != cur_line) || (x_cnt[0] != half));

    // Line start word must already be at the head one cycle early.
    assign lock_hit = (i_hcnt == HPRE) && act_v && !i_fifo_empty
                    && (y_cnt == cur_line) && (x_cnt == 2'd0);

    assign hold_hit = (y_cnt == next_line) && (x_cnt == 2'd0);

    always_comb begin
        rd = 1'b0;
        if (state_q == HUNT) begin
            if (!act && !i_fifo_empty) begin
                rd = !lock_hit && !hold_hit;
            end
        end else if (act) begin
            rd = !i_fifo_empty && !mismatch;
        end
    end

    assign o_fifo_rd = rd && i_rst_n;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pix_data_d  = BLANK_YC;
        pix_valid_d = act;
        resync_d    = 1'b0;
        if (state_q == HUNT) begin
            if (lock_hit) begin
                state_d = LOCK;
                pend_d  = 1'b0;
            end
        end else if (act) begin
            if (mismatch) begin
                state_d  = HUNT;
                pend_d   = 1'b0;
                resync_d = 1'b1;
            end else begin
                if (i_fifo_empty) begin
                    if (hoff == 12'd0) begin
                        pend_d = 1'b1;
                    end
                end else begin
                    pix_data_d = i_fifo_dout[15:0];
                end
                // Empty at line start: give up lock quietly at line end.
                if ((hoff == HLAST) && pend_d) begin
                    state_d = HUNT;
                    pend_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk_74M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= HUNT;
            pend_q      <= 1'b0;
            pix_data_q  <= BLANK_YC;
            pix_valid_q <= 1'b0;
            resync_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            resync_q    <= resync_d;
        end
    end

    assign o_pix_data  = pix_data_q;
    assign o_pix_valid = pix_valid_q;
    assign o_locked    = (state_q == LOCK);
    assign o_resync    = resync_q;

`ifdef STATS_EN
    logic [15:0] ufl_cnt_q, ufl_cnt_d;
    logic [15:0] rsc_cnt_q, rsc_cnt_d;
    logic        underflow, to_hunt, frame_clr;

    assign underflow = (state_q == LOCK) && act && i_fifo_empty;
    assign to_hunt   = (state_q == LOCK) && (state_d == HUNT);
    assign frame_clr = (i_vcnt == 12'd0) && (i_hcnt == 12'd0);

    always_comb begin
        ufl_cnt_d = ufl_cnt_q;
        rsc_cnt_d = rsc_cnt_q;
        if (frame_clr) begin
            ufl_cnt_d = 16'h0;
            rsc_cnt_d = 16'h0;
        end else begin
            if (underflow && (ufl_cnt_q != 16'hFFFF)) begin
                ufl_cnt_d = ufl_cnt_q + 16'd1;
            end
            if (to_hunt && (rsc_cnt_q != 16'hFFFF)) begin
                rsc_cnt_d = rsc_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk_74M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ufl_cnt_q <= 16'h0;
            rsc_cnt_q <= 16'h0;
        end else begin
            ufl_cnt_q <= ufl_cnt_d;
            rsc_cnt_q <= rsc_cnt_d;
        end
    end

    assign o_underflow_cnt = ufl_cnt_q;
    assign o_resync_cnt    = rsc_cnt_q;
`else
    assign o_underflow_cnt = 16'h0;
    assign o_resync_cnt    = 16'h0;
`endif

endmodule

// File: tb/tb_line_sync_ctrl.sv
// tb_line_sync_ctrl: random FIFO stream with injected faults, checked
// against a line/pixel-level reference model through a scoreboard.
module tb_line_sync_ctrl;

    localparam int HS = 1;
    localparam int HA = 16;
    localparam int VS = 2;
    localparam int VA = 6;
    localparam int HT = 24;
    localparam int VT = 10;
    localparam int NF = 40;
    localparam logic [15:0] BLK = 16'h1080;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] vcnt  = '0;
    logic [11:0] hcnt  = '0;
    logic [28:0] dout  = '0;
    logic        empty = 1'b1;
    logic        rd, pvalid, locked, resync;
    logic [15:0] pdata, ucnt, rcnt;

    always #5 clk = ~clk;

    line_sync_ctrl #(
        .HSTART(12'(HS)),
        .HACT  (12'(HA)),
        .VSTART(12'(VS)),
        .VACT  (12'(VA))
    ) dut (
        .i_clk_74M      (clk),
        .i_rst_n        (rst_n),
        .i_vcnt         (vcnt),
        .i_hcnt         (hcnt),
        .i_fifo_dout    (dout),
        .i_fifo_empty   (empty),
        .o_fifo_rd      (rd),
        .o_pix_data     (pdata),
        .o_pix_valid    (pvalid),
        .o_locked       (locked),
        .o_resync       (resync),
        .o_underflow_cnt(ucnt),
        .o_resync_cnt   (rcnt)
    );

    typedef struct {
        logic [15:0] data;
        logic        valid;
        logic        locked;
        logic        resync;
        logic [15:0] uc;
        logic [15:0] rc;
    } exp_t;

    exp_t        sbq[$];
    logic [28:0] fifo[$];
    logic [28:0] mq[$];
    logic [28:0] src[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    bit          m_lock = 1'b0;
    bit          m_pend = 1'b0;
    int          m_uc   = 0;
    int          m_rc   = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h",
                      nm, $time, a, e);
    endtask

    function automatic logic [28:0] mkw(int x, int y, int d);
        return {2'(x), 11'(y), 16'(d)};
    endfunction

    // ft: 0 drop line, 1 bad x at half, 2 junk before, 3 lose a word
    task automatic gen_line(input int y, input int ft);
        int x;
        if (ft == 2) begin
            repeat (3) src.push_back(mkw($urandom_range(0, 3), 7, $urandom));
        end
        if (ft != 0) begin
            for (int i = 0; i < HA; i++) begin
                x = (i >= HA / 2) ? 1 : 0;
                if (ft == 1 && i == HA / 2) x = 0;
                if (!(ft == 3 && i == 3)) src.push_back(mkw(x, y, $urandom));
            end
        end
    endtask

    task automatic model_reset();
        m_lock = 1'b0;
        m_pend = 1'b0;
        m_uc   = 0;
        m_rc   = 0;
    endtask

    task automatic model_step(input bit gap, output bit erd, output exp_t e);
        int h, v, line, px, want, hy;
        bit ah, av, a, emp, half;
        logic [28:0] hw;
        logic [1:0]  hx;
        h    = int'(hcnt);
        v    = int'(vcnt);
        ah   = (h >= HS) && (h < HS + HA);
        av   = (v >= VS) && (v < VS + VA);
        a    = ah && av;
        line = v - VS;
        px   = h - HS;
        emp  = gap || (mq.size() == 0);
        hw   = (mq.size() > 0) ? mq[0] : '0;
        hx   = hw[28:27];
        hy   = int'(hw[26:16]);
        erd  = 1'b0;
        e.data   = BLK;
        e.valid  = a;
        e.resync = 1'b0;
        if (!m_lock) begin
            if (!a && !emp) begin
                want = av ? line + 1 : 0;
                if (h == HS - 1 && av && hy == line && hx == 2'd0) begin
                    m_lock = 1'b1;
                    m_pend = 1'b0;
                end else begin
                    erd = !(hy == want && hx == 2'd0);
                end
            end
        end else if (a) begin
            half = px >= HA / 2;
            if ((px == 0 || px == HA / 2) && !emp
                && (hy != line || hx[0] != half)) begin
                m_lock   = 1'b0;
                m_pend   = 1'b0;
                e.resync = 1'b1;
                m_rc++;
            end else if (emp) begin
                m_uc++;
                if (px == 0) m_pend = 1'b1;
            end else begin
                erd    = 1'b1;
                e.data = hw[15:0];
            end
            if (m_lock && m_pend && px == HA - 1) begin
                m_lock = 1'b0;
                m_pend = 1'b0;
                m_rc++;
            end
        end
        if (m_uc > 65535) m_uc = 65535;
        if (m_rc > 65535) m_rc = 65535;
        if (v == 0 && h == 0) begin
            m_uc = 0;
            m_rc = 0;
        end
        if (erd) mq.delete(0);
        e.locked = m_lock;
`ifdef STATS_EN
        e.uc = 16'(m_uc);
        e.rc = 16'(m_rc);
`else
        e.uc = 16'h0;
        e.rc = 16'h0;
`endif
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("pix_valid", 32'(pvalid), 32'(e.valid));
                chk("pix_data", 32'(pdata), 32'(e.data));
                chk("locked", 32'(locked), 32'(e.locked));
                chk("resync", 32'(resync), 32'(e.resync));
                chk("underflow_cnt", 32'(ucnt), 32'(e.uc));
                chk("resync_cnt", 32'(rcnt), 32'(e.rc));
            end
        end
    end

    initial begin : drv
        exp_t        pe;
        bit          have_pe;
        bit          rd_seen;
        bit          erd;
        bit          gap;
        bit          in_rst;
        int          rate;
        int          cap;
        int          ft;
        logic [28:0] w;
        have_pe = 1'b0;
        rd_seen = 1'b0;
        rate    = 100;
        cap     = 32;

        repeat (5) src.push_back(mkw(0, 7, $urandom));
        for (int f = 0; f < NF; f++) begin
            for (int l = 0; l < VA; l++) begin
                ft = 9;
                if (f == 2 && l == 4) ft = 0;
                if (f == 4 && l == 2) ft = 1;
                if (f >= 6) ft = $urandom_range(0, 23);
                gen_line(l, ft);
            end
        end

        #1 rst_n = 1'b0;
        empty = 1'b0;
        dout  = 29'h1ABCDEF;
        #2;
        chk("rst_valid", 32'(pvalid), 32'd0);
        chk("rst_data", 32'(pdata), 32'(BLK));
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_resync", 32'(resync), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_ucnt", 32'(ucnt), 32'd0);
        chk("rst_rcnt", 32'(rcnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_clk", 32'(rd), 32'd0);
        chk("rst_valid_clk", 32'(pvalid), 32'd0);
        empty = 1'b1;

        for (int f = 0; f < NF; f++) begin
            for (int v = 0; v < VT; v++) begin
                for (int h = 0; h < HT; h++) begin
                    @(posedge clk);
                    if (have_pe) sbq.push_back(pe);
                    if (rd_seen && fifo.size() > 0) fifo.delete(0);
                    #1;
                    if (h == 0 && f >= 6) begin
                        rate = $urandom_range(70, 100);
                        cap  = $urandom_range(4, 32);
                    end
                    in_rst = (f == 3 && v == VS + 2
                              && h >= HS + 9 && h < HS + 12);
                    if (fifo.size() < cap && src.size() > 0
                        && $urandom_range(0, 99) < rate) begin
                        w = src.pop_front();
                        fifo.push_back(w);
                        mq.push_back(w);
                    end
                    gap = (f == 1 && v == VS + 3 && h >= HS + 6 && h < HS + 9)
                       || (f >= 6 && $urandom_range(0, 99) < 2);
                    hcnt  = 12'(h);
                    vcnt  = 12'(v);
                    empty = gap || (fifo.size() == 0);
                    dout  = (fifo.size() > 0) ? fifo[0] : 29'($urandom);
                    if (in_rst) begin
                        rst_n = 1'b0;
                        model_reset();
                        sbq.delete();
                        have_pe = 1'b0;
                        #1;
                        chk("mid_rst_valid", 32'(pvalid), 32'd0);
                        chk("mid_rst_data", 32'(pdata), 32'(BLK));
                        chk("mid_rst_locked", 32'(locked), 32'd0);
                        chk("mid_rst_rd", 32'(rd), 32'd0);
                        rd_seen = rd;
                    end else begin
                        rst_n = 1'b1;
                        model_step(gap, erd, pe);
                        have_pe = 1'b1;
                        #1;
                        chk("fifo_rd", 32'(rd), 32'(erd));
                        rd_seen = rd;
                    end
                end
            end
        end
        @(posedge clk);
        if (have_pe) sbq.push_back(pe);
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
